// File: rtl/taylor_out_fifo.sv
// Output capture FIFO for the Taylor-series processor: tags, narrows and buffers results onto a valid/ready stream.
// Optional feature: define TAYLOR_OUT_SAT_EN for saturating narrowing (otherwise two's-complement wrap).
module taylor_out_fifo #(
  parameter int DW    = 28,
  parameter int OW    = 19,
  parameter int NPORT = 4,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    io_out,
  input  logic [NPORT-1:0] out_en,
  output logic [OW-1:0]    m_data,
  output logic [1:0]       m_port,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic [7:0]       ovf_cnt,
  output logic             sat_flag,
  output logic             oh_err
);

  logic [OW+1:0] mem [DEPTH];

  logic [AW:0]   wp_q, wp_d, rp_q, rp_d, count_q, count_d;
  logic [OW-1:0] m_data_q, narrow;
  logic [1:0]    m_port_q, port_sel;
  logic          m_valid_q, valid_d, full_q, full_d, empty_q, empty_d;
  logic [7:0]    ovf_q, ovf_d;
  logic          sat_q, oh_q, clip, found, multi;
  logic          wr_req, rd_en, wr_en;
  logic [OW+1:0] wr_entry, head_d;

  always_comb begin
    port_sel = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      if (out_en[i] && !found) begin
        port_sel = 2'(i);
        found    = 1'b1;
      end
    end
  end

  assign multi = |(out_en & (out_en - NPORT'(1)));

`ifdef TAYLOR_OUT_SAT_EN
  logic [DW-OW:0] hi_bits;
  assign hi_bits = io_out[DW-1:OW-1];
  // Value fits only when the dropped bits all match the new sign bit.
  assign clip    = !((&hi_bits) || (~|hi_bits));
  assign narrow  = !clip        ? io_out[OW-1:0] :
                   io_out[DW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
`else
  logic unused_hi;
  assign unused_hi = ^io_out[DW-1:OW];
  assign clip      = 1'b0;
  assign narrow    = io_out[OW-1:0];
`endif

  assign wr_entry = {port_sel, narrow};
  assign wr_req   = |out_en;
  assign rd_en    = m_valid_q & m_ready;
  assign wr_en    = wr_req & (~full_q | rd_en);

  always_comb begin
    wp_d    = wp_q + (AW+1)'(wr_en);
    rp_d    = rp_q + (AW+1)'(rd_en);
    count_d = wp_d - rp_d;
    valid_d = (wp_d != rp_d);
    empty_d = (wp_d == rp_d);
    full_d  = ((wp_d ^ rp_d) == {1'b1, {AW{1'b0}}});
    // New head is the entry being written this cycle when it lands in the slot rp moves to.
    if (wr_en && (rp_d == wp_q)) head_d = wr_entry;
    else                         head_d = mem[rp_d[AW-1:0]];
    ovf_d = ovf_q;
    if (wr_req && full_q && !rd_en && (ovf_q != 8'hFF)) ovf_d = ovf_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wp_q[AW-1:0]] <= wr_entry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q      <= '0;
      rp_q      <= '0;
      count_q   <= '0;
      m_valid_q <= 1'b0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      m_data_q  <= '0;
      m_port_q  <= '0;
      ovf_q     <= '0;
      sat_q     <= 1'b0;
      oh_q      <= 1'b0;
    end else begin
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      count_q   <= count_d;
      m_valid_q <= valid_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
      if (valid_d) begin
        m_port_q <= head_d[OW+1:OW];
        m_data_q <= head_d[OW-1:0];
      end
      if (wr_en && clip) sat_q <= 1'b1;
      if (multi)         oh_q  <= 1'b1;
    end
  end

  assign m_data   = m_data_q;
  assign m_port   = m_port_q;
  assign m_valid  = m_valid_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign ovf_cnt  = ovf_q;
  assign sat_flag = sat_q;
  assign oh_err   = oh_q;

endmodule

// File: tb/tb_taylor_out_fifo.sv
// Self-checking bench for taylor_out_fifo using a queue-based reference model.
module tb_taylor_out_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [27:0] io_out;
  logic [3:0]  out_en;
  logic        m_ready;
  logic [18:0] m_data;
  logic [1:0]  m_port;
  logic        m_valid, full, empty, sat_flag, oh_err;
  logic [4:0]  count;
  logic [7:0]  ovf_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct { int port; int data; } ent_t;
  ent_t q[$];
  int   mdl_ovf;
  bit   mdl_sat, mdl_oh;

  always #5 clk = ~clk;

  taylor_out_fifo #(.DW(28), .OW(19), .NPORT(4), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .io_out(io_out), .out_en(out_en),
    .m_data(m_data), .m_port(m_port), .m_valid(m_valid), .m_ready(m_ready),
    .full(full), .empty(empty), .count(count), .ovf_cnt(ovf_cnt),
    .sat_flag(sat_flag), .oh_err(oh_err)
  );

  function automatic bit clips(int v);
`ifdef TAYLOR_OUT_SAT_EN
    return (v > 262143) || (v < -262144);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int narrow_ref(int v);
`ifdef TAYLOR_OUT_SAT_EN
    if (v > 262143)  return 262143;
    if (v < -262144) return -262144;
    return v;
`else
    int w;
    w = v & 32'h7FFFF;
    if (w >= 262144) w = w - 524288;
    return w;
`endif
  endfunction

  task automatic drive(input logic [3:0] en, input int val, input logic rdy);
    out_en  = en;
    io_out  = 28'(val);
    m_ready = rdy;
  endtask

  // Applies the current inputs to the model, then advances one clock (inputs and samples sit 1ns after the edge).
  task automatic cycle();
    int   sz;
    bit   rd;
    ent_t e;
    sz = q.size();
    rd = (sz != 0) && m_ready;
    if (rd) void'(q.pop_front());
    if (out_en != 4'b0) begin
      if ($countones(out_en) > 1) mdl_oh = 1'b1;
      e.port = 0;
      for (int i = 3; i >= 0; i--) if (out_en[i]) e.port = i;
      e.data = narrow_ref(int'($signed(io_out)));
      if (sz == 16 && !rd) begin
        if (mdl_ovf < 255) mdl_ovf++;
      end else begin
        q.push_back(e);
        if (clips(int'($signed(io_out)))) mdl_sat = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(4'b0, 0, 1'b0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    mdl_ovf = 0;
    mdl_sat = 1'b0;
    mdl_oh  = 1'b0;
  endtask

  task automatic test_reset();
    drive(4'b0, 0, 1'b0);
    rst = 1'b0;
    #13;
    checks++;
    if ({m_valid, empty, full, count, ovf_cnt, sat_flag, oh_err, m_data, m_port} !== {1'b0, 1'b1, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 19'd0, 2'd0}) begin
      errors++;
      $display("FAIL reset_state: got v=%0b e=%0b f=%0b cnt=%0d ovf=%0d sat=%0b oh=%0b data=%0d port=%0d, want v=0 e=1 f=0 cnt=0 ovf=0 sat=0 oh=0 data=0 port=0",
               m_valid, empty, full, count, ovf_cnt, sat_flag, oh_err, m_data, m_port);
    end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    drive(4'b0010, -5, 1'b0);
    cycle();
    checks++;
    if ({m_valid, m_port, count} !== {1'b1, 2'd1, 5'd1} || int'($signed(m_data)) != -5) begin
      errors++;
      $display("FAIL basic_write: got v=%0b data=%0d port=%0d cnt=%0d, want v=1 data=-5 port=1 cnt=1",
               m_valid, $signed(m_data), m_port, count);
    end
    drive(4'b0, 0, 1'b1);
    cycle();
    checks++;
    if ({empty, m_valid, count} !== {1'b1, 1'b0, 5'd0}) begin
      errors++;
      $display("FAIL basic_read: got e=%0b v=%0b cnt=%0d, want e=1 v=0 cnt=0", empty, m_valid, count);
    end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 0; i < 18; i++) begin
      drive(4'b0001, i, 1'b0);
      cycle();
    end
    checks++;
    if ({full, empty, count, ovf_cnt} !== {1'b1, 1'b0, 5'd16, 8'd2}) begin
      errors++;
      $display("FAIL fill_ovf: got f=%0b e=%0b cnt=%0d ovf=%0d, want f=1 e=0 cnt=16 ovf=2", full, empty, count, ovf_cnt);
    end
    drive(4'b0, 0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (m_valid !== 1'b1 || int'($signed(m_data)) != i || m_port !== 2'd0) begin
        errors++;
        $display("FAIL drain_order[%0d]: got v=%0b data=%0d port=%0d, want v=1 data=%0d port=0", i, m_valid, $signed(m_data), m_port, i);
      end
      cycle();
    end
    checks++;
    if ({empty, m_valid, count, ovf_cnt} !== {1'b1, 1'b0, 5'd0, 8'd2}) begin
      errors++;
      $display("FAIL drained: got e=%0b v=%0b cnt=%0d ovf=%0d, want e=1 v=0 cnt=0 ovf=2", empty, m_valid, count, ovf_cnt);
    end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 16; i++) begin
      drive(4'b0001, 100 + i, 1'b0);
      cycle();
    end
    drive(4'b1000, 7, 1'b1);
    cycle();
    checks++;
    if ({full, count, ovf_cnt} !== {1'b1, 5'd16, 8'd2}) begin
      errors++;
      $display("FAIL full_rw: got f=%0b cnt=%0d ovf=%0d, want f=1 cnt=16 ovf=2", full, count, ovf_cnt);
    end
    drive(4'b0, 0, 1'b1);
    for (int i = 1; i < 16; i++) begin
      checks++;
      if (int'($signed(m_data)) != 100 + i || m_port !== 2'd0) begin
        errors++;
        $display("FAIL full_rw_drain[%0d]: got data=%0d port=%0d, want data=%0d port=0", i, $signed(m_data), m_port, 100 + i);
      end
      cycle();
    end
    checks++;
    if (m_valid !== 1'b1 || int'($signed(m_data)) != 7 || m_port !== 2'd3) begin
      errors++;
      $display("FAIL full_rw_last: got v=%0b data=%0d port=%0d, want v=1 data=7 port=3", m_valid, $signed(m_data), m_port);
    end
    cycle();
  endtask

  task automatic test_narrow();
    int  exp1, exp2;
    bit  exp_sat;
`ifdef TAYLOR_OUT_SAT_EN
    exp1 = 262143; exp2 = -262144; exp_sat = 1'b1;
`else
    exp1 = -224288; exp2 = 224288; exp_sat = 1'b0;
`endif
    do_reset();
    drive(4'b0100, 300000, 1'b0);
    cycle();
    checks++;
    if (int'($signed(m_data)) != exp1 || m_port !== 2'd2 || sat_flag !== exp_sat) begin
      errors++;
      $display("FAIL narrow_pos: got data=%0d port=%0d sat=%0b, want data=%0d port=2 sat=%0b", $signed(m_data), m_port, sat_flag, exp1, exp_sat);
    end
    drive(4'b0100, -300000, 1'b1);
    cycle();
    checks++;
    if (int'($signed(m_data)) != exp2 || count !== 5'd1 || sat_flag !== exp_sat) begin
      errors++;
      $display("FAIL narrow_neg: got data=%0d cnt=%0d sat=%0b, want data=%0d cnt=1 sat=%0b", $signed(m_data), count, sat_flag, exp2, exp_sat);
    end
  endtask

  task automatic test_onehot();
    do_reset();
    drive(4'b0110, 9, 1'b0);
    cycle();
    checks++;
    if ({m_valid, m_port, count, oh_err} !== {1'b1, 2'd1, 5'd1, 1'b1} || int'($signed(m_data)) != 9) begin
      errors++;
      $display("FAIL onehot_err: got v=%0b port=%0d data=%0d cnt=%0d oh=%0b, want v=1 port=1 data=9 cnt=1 oh=1",
               m_valid, m_port, $signed(m_data), count, oh_err);
    end
    drive(4'b0, 0, 1'b1);
    repeat (3) cycle();
    checks++;
    if ({oh_err, empty} !== 2'b11) begin
      errors++;
      $display("FAIL onehot_sticky: got oh=%0b e=%0b, want oh=1 e=1", oh_err, empty);
    end
  endtask

  task automatic test_random();
    int r;
    logic [3:0] en;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      en = 4'b0;
      else if (r < 8) en = 4'(1 << $urandom_range(0, 3));
      else            en = 4'($urandom);
      if ($urandom_range(0, 3) == 0) r = int'($signed(28'($urandom)));
      else                           r = $urandom_range(0, 2000) - 1000;
      drive(en, r, (n % 200 < 60) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 2) != 0));
      cycle();
      checks++;
      if (m_valid !== (q.size() != 0) || count !== 5'(q.size()) || full !== (q.size() == 16) || empty !== (q.size() == 0) ||
          ovf_cnt !== 8'(mdl_ovf) || sat_flag !== mdl_sat || oh_err !== mdl_oh ||
          (q.size() != 0 && (int'($signed(m_data)) != q[0].data || m_port !== 2'(q[0].port)))) begin
        errors++;
        $display("FAIL random[%0d]: got v=%0b cnt=%0d f=%0b e=%0b ovf=%0d sat=%0b oh=%0b data=%0d port=%0d, want cnt=%0d ovf=%0d sat=%0b oh=%0b data=%0d port=%0d",
                 n, m_valid, count, full, empty, ovf_cnt, sat_flag, oh_err, $signed(m_data), m_port,
                 q.size(), mdl_ovf, mdl_sat, mdl_oh, (q.size() != 0) ? q[0].data : 0, (q.size() != 0) ? q[0].port : 0);
      end
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive((i == 2) ? 4'b0011 : 4'b0100, (i == 3) ? 300000 : 40 + i, 1'b0);
      cycle();
    end
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if ({m_valid, count, ovf_cnt, sat_flag, oh_err, empty} !== {1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid: got v=%0b cnt=%0d ovf=%0d sat=%0b oh=%0b e=%0b, want v=0 cnt=0 ovf=0 sat=0 oh=0 e=1",
               m_valid, count, ovf_cnt, sat_flag, oh_err, empty);
    end
    do_reset();
    drive(4'b1000, -77, 1'b0);
    cycle();
    drive(4'b0, 0, 1'b0);
    cycle();
    checks++;
    if ({m_valid, count, m_port} !== {1'b1, 5'd1, 2'd3} || int'($signed(m_data)) != -77) begin
      errors++;
      $display("FAIL reset_after: got v=%0b cnt=%0d port=%0d data=%0d, want v=1 cnt=1 port=3 data=-77",
               m_valid, count, m_port, $signed(m_data));
    end
  endtask

  initial begin
    drive(4'b0, 0, 1'b0);
    rst = 1'b1;
    #2;
    test_reset();
    test_basic();
    test_fill_overflow();
    test_full_rw();
    test_narrow();
    test_onehot();
    test_random();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
